// File: rtl/scm_wb_scheduler.sv
// Write-back scheduler: in-order FIFO feeding the two registered write ports of the 2W SCM register file.
// Optional bypass lookup over pending writes is enabled with `define SCM_WB_BYPASS_EN.
module scm_wb_scheduler #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p0_valid_i,
    input  logic [ADDR_WIDTH-1:0] p0_addr_i,
    input  logic [DATA_WIDTH-1:0] p0_data_i,
    output logic                  p0_ready_o,
    input  logic                  p1_valid_i,
    input  logic [ADDR_WIDTH-1:0] p1_addr_i,
    input  logic [DATA_WIDTH-1:0] p1_data_i,
    output logic                  p1_ready_o,
    input  logic                  wb_stall_i,
    output logic                  we_a_o,
    output logic [ADDR_WIDTH-1:0] waddr_a_o,
    output logic [DATA_WIDTH-1:0] wdata_a_o,
    output logic                  we_b_o,
    output logic [ADDR_WIDTH-1:0] waddr_b_o,
    output logic [DATA_WIDTH-1:0] wdata_b_o,
    input  logic [ADDR_WIDTH-1:0] byp_raddr_i,
    output logic                  byp_hit_o,
    output logic [DATA_WIDTH-1:0] byp_rdata_o,
    output logic                  idle_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d, head1, tail1;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  we_a_q, we_a_d, we_b_q, we_b_d;
    logic [ADDR_WIDTH-1:0] waddr_a_q, waddr_a_d, waddr_b_q, waddr_b_d;
    logic [DATA_WIDTH-1:0] wdata_a_q, wdata_a_d, wdata_b_q, wdata_b_d;
    logic                  ready, push0, push1;
    logic [1:0]            n_push, n_pop;

    // Modular pointer advance; DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int n);
        int s;
        s = int'(p) + n;
        if (s >= DEPTH) s = s - DEPTH;
        return PTR_W'(s);
    endfunction

    // Ready looks only at the registered count so it never depends on valid or on this cycle's pop.
    assign ready  = (int'(count_q) <= DEPTH - 2);
    assign push0  = p0_valid_i && ready;
    assign push1  = p1_valid_i && ready;
    assign n_push = {1'b0, push0} + {1'b0, push1};
    assign head1  = ptr_add(head_q, 1);
    assign tail1  = ptr_add(tail_q, 1);

    always_comb begin
        we_a_d    = 1'b0;
        we_b_d    = 1'b0;
        waddr_a_d = waddr_a_q;
        wdata_a_d = wdata_a_q;
        waddr_b_d = waddr_b_q;
        wdata_b_d = wdata_b_q;
        n_pop     = 2'd0;
        if (!wb_stall_i && count_q != '0) begin
            if (count_q == CNT_W'(1)) begin
                we_a_d    = 1'b1;
                waddr_a_d = addr_q[head_q];
                wdata_a_d = data_q[head_q];
                n_pop     = 2'd1;
            end else if (addr_q[head_q] != addr_q[head1]) begin
                we_a_d    = 1'b1;
                waddr_a_d = addr_q[head_q];
                wdata_a_d = data_q[head_q];
                we_b_d    = 1'b1;
                waddr_b_d = addr_q[head1];
                wdata_b_d = data_q[head1];
                n_pop     = 2'd2;
            end else begin
                // Same destination: the older write is dead, only the younger reaches the file.
                we_a_d    = 1'b1;
                waddr_a_d = addr_q[head1];
                wdata_a_d = data_q[head1];
                n_pop     = 2'd2;
            end
        end
        head_d  = ptr_add(head_q, int'(n_pop));
        tail_d  = ptr_add(tail_q, int'(n_push));
        count_d = count_q + CNT_W'(n_push) - CNT_W'(n_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            we_a_q    <= 1'b0;
            we_b_q    <= 1'b0;
            waddr_a_q <= '0;
            wdata_a_q <= '0;
            waddr_b_q <= '0;
            wdata_b_q <= '0;
        end else begin
            if (push0) begin
                addr_q[tail_q] <= p0_addr_i;
                data_q[tail_q] <= p0_data_i;
            end
            if (push1) begin
                addr_q[push0 ? tail1 : tail_q] <= p1_addr_i;
                data_q[push0 ? tail1 : tail_q] <= p1_data_i;
            end
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            we_a_q    <= we_a_d;
            we_b_q    <= we_b_d;
            waddr_a_q <= waddr_a_d;
            wdata_a_q <= wdata_a_d;
            waddr_b_q <= waddr_b_d;
            wdata_b_q <= wdata_b_d;
        end
    end

    assign p0_ready_o = ready;
    assign p1_ready_o = ready;
    assign we_a_o     = we_a_q;
    assign waddr_a_o  = waddr_a_q;
    assign wdata_a_o  = wdata_a_q;
    assign we_b_o     = we_b_q;
    assign waddr_b_o  = waddr_b_q;
    assign wdata_b_o  = wdata_b_q;
    assign idle_o     = (count_q == '0) && !we_a_q && !we_b_q;

`ifdef SCM_WB_BYPASS_EN
    logic [PTR_W-1:0] byp_idx;

    // Scan oldest to newest so the last match wins: A, B, then FIFO head towards tail.
    always_comb begin
        byp_hit_o   = 1'b0;
        byp_rdata_o = '0;
        byp_idx     = head_q;
        if (we_a_q && waddr_a_q == byp_raddr_i) begin
            byp_hit_o   = 1'b1;
            byp_rdata_o = wdata_a_q;
        end
        if (we_b_q && waddr_b_q == byp_raddr_i) begin
            byp_hit_o   = 1'b1;
            byp_rdata_o = wdata_b_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            byp_idx = ptr_add(head_q, i);
            if (i < int'(count_q) && addr_q[byp_idx] == byp_raddr_i) begin
                byp_hit_o   = 1'b1;
                byp_rdata_o = data_q[byp_idx];
            end
        end
    end
`else
    logic byp_unused;
    assign byp_unused  = ^byp_raddr_i;
    assign byp_hit_o   = 1'b0;
    assign byp_rdata_o = '0;
`endif

endmodule

// File: tb/tb_scm_wb_scheduler.sv
// Scoreboard bench for scm_wb_scheduler: queue-level reference model predicts issue events, a negedge monitor checks them.
module tb_scm_wb_scheduler;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          p0_valid_i, p1_valid_i, wb_stall_i;
    logic [AW-1:0] p0_addr_i, p1_addr_i, byp_raddr_i;
    logic [DW-1:0] p0_data_i, p1_data_i;
    logic          p0_ready_o, p1_ready_o, we_a_o, we_b_o, byp_hit_o, idle_o;
    logic [AW-1:0] waddr_a_o, waddr_b_o;
    logic [DW-1:0] wdata_a_o, wdata_b_o, byp_rdata_o;

    scm_wb_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_valid_i(p0_valid_i), .p0_addr_i(p0_addr_i), .p0_data_i(p0_data_i), .p0_ready_o(p0_ready_o),
        .p1_valid_i(p1_valid_i), .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i), .p1_ready_o(p1_ready_o),
        .wb_stall_i(wb_stall_i),
        .we_a_o(we_a_o), .waddr_a_o(waddr_a_o), .wdata_a_o(wdata_a_o),
        .we_b_o(we_b_o), .waddr_b_o(waddr_b_o), .wdata_b_o(wdata_b_o),
        .byp_raddr_i(byp_raddr_i), .byp_hit_o(byp_hit_o), .byp_rdata_o(byp_rdata_o),
        .idle_o(idle_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
    typedef struct {
        int            e_edge;
        bit            b_en;
        logic [AW-1:0] aa;
        logic [DW-1:0] ad;
        logic [AW-1:0] ba;
        logic [DW-1:0] bd;
    } ev_t;

    wr_t  mq[$];
    ev_t  exq[$];
    bit   la_en, lb_en;
    wr_t  la, lb;
    int   edge_n = 0;
    int   checks = 0;
    int   failures = 0;
    bit   run = 1'b0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Reference model: one clock edge acting on the pending-write queue.
    task automatic model_edge(input bit v0, input wr_t w0, input bit v1, input wr_t w1, input bit st);
        bit  rdy;
        ev_t ev;
        wr_t x, y;
        rdy   = (DEPTH - mq.size()) >= 2;
        la_en = 1'b0;
        lb_en = 1'b0;
        if (!st && mq.size() > 0) begin
            ev.e_edge = edge_n;
            ev.b_en   = 1'b0;
            ev.ba     = '0;
            ev.bd     = '0;
            x = mq.pop_front();
            if (mq.size() == 0) begin
                ev.aa = x.a; ev.ad = x.d;
            end else begin
                y = mq.pop_front();
                if (x.a != y.a) begin
                    ev.aa = x.a; ev.ad = x.d;
                    ev.b_en = 1'b1; ev.ba = y.a; ev.bd = y.d;
                end else begin
                    ev.aa = y.a; ev.ad = y.d;
                end
            end
            la_en = 1'b1; la.a = ev.aa; la.d = ev.ad;
            lb_en = ev.b_en; lb.a = ev.ba; lb.d = ev.bd;
            exq.push_back(ev);
        end
        if (rdy) begin
            if (v0) mq.push_back(w0);
            if (v1) mq.push_back(w1);
        end
    endtask

    task automatic step(input bit v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input bit v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input bit st, input logic [AW-1:0] br);
        wr_t w0, w1;
        bit hit;
        logic [DW-1:0] rd;
        p0_valid_i = v0; p0_addr_i = a0; p0_data_i = d0;
        p1_valid_i = v1; p1_addr_i = a1; p1_data_i = d1;
        wb_stall_i = st; byp_raddr_i = br;
        #1;
        hit = 1'b0; rd = '0;
`ifdef SCM_WB_BYPASS_EN
        if (la_en && la.a == br) begin hit = 1'b1; rd = la.d; end
        if (lb_en && lb.a == br) begin hit = 1'b1; rd = lb.d; end
        foreach (mq[i]) if (mq[i].a == br) begin hit = 1'b1; rd = mq[i].d; end
`endif
        chk("byp_hit", {31'd0, byp_hit_o}, {31'd0, hit});
        chk("byp_rdata", byp_rdata_o, rd);
        w0.a = a0; w0.d = d0; w1.a = a1; w1.d = d1;
        @(posedge clk);
        edge_n++;
        model_edge(v0, w0, v1, w1, st);
        @(negedge clk);
        #1;
    endtask

    task automatic idle_step(input bit st);
        step(1'b0, '0, '0, 1'b0, '0, '0, st, AW'($urandom_range(0, 15)));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mq.delete(); exq.delete();
        la_en = 1'b0; lb_en = 1'b0;
        #1;
        chk("rst_we_a", {31'd0, we_a_o}, 32'd0);
        chk("rst_we_b", {31'd0, we_b_o}, 32'd0);
        chk("rst_idle", {31'd0, idle_o}, 32'd1);
        chk("rst_ready", {30'd0, p0_ready_o, p1_ready_o}, 32'd3);
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compares whatever the DUT presents against the oldest predicted issue event.
    always @(negedge clk) begin
        if (run && rst_n) begin
            if (we_a_o || we_b_o) begin
                if (exq.size() == 0) begin
                    chk("unexpected_issue", {30'd0, we_a_o, we_b_o}, 32'd0);
                end else begin
                    ev_t ev;
                    ev = exq.pop_front();
                    chk("issue_edge", edge_n, ev.e_edge);
                    chk("we_a", {31'd0, we_a_o}, 32'd1);
                    chk("waddr_a", {27'd0, waddr_a_o}, {27'd0, ev.aa});
                    chk("wdata_a", wdata_a_o, ev.ad);
                    chk("we_b", {31'd0, we_b_o}, {31'd0, ev.b_en});
                    if (ev.b_en) begin
                        chk("waddr_b", {27'd0, waddr_b_o}, {27'd0, ev.ba});
                        chk("wdata_b", wdata_b_o, ev.bd);
                    end
                end
            end else if (exq.size() > 0 && exq[0].e_edge <= edge_n) begin
                chk("missing_issue", 32'd0, 32'd1);
                void'(exq.pop_front());
            end
            chk("ready", {30'd0, p0_ready_o, p1_ready_o},
                ((DEPTH - mq.size()) >= 2) ? 32'd3 : 32'd0);
            chk("idle", {31'd0, idle_o}, {31'd0, (mq.size() == 0 && !la_en && !lb_en)});
        end
    end

    initial begin
        rst_n = 1'b0;
        p0_valid_i = 1'b0; p1_valid_i = 1'b0; wb_stall_i = 1'b0;
        p0_addr_i = '0; p1_addr_i = '0; p0_data_i = '0; p1_data_i = '0; byp_raddr_i = '0;
        @(negedge clk);
        #1;
        chk("init_we_a", {31'd0, we_a_o}, 32'd0);
        chk("init_idle", {31'd0, idle_o}, 32'd1);
        chk("init_ready", {30'd0, p0_ready_o, p1_ready_o}, 32'd3);
        rst_n = 1'b1;
        run = 1'b1;

        // Single P0 write, then a distinct pair, then a same-address pair.
        step(1'b1, 5'd3, 32'hAAAA0001, 1'b0, '0, '0, 1'b0, 5'd3);
        repeat (3) idle_step(1'b0);
        step(1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h22, 1'b0, 5'd6);
        repeat (3) idle_step(1'b0);
        step(1'b1, 5'd7, 32'h01, 1'b1, 5'd7, 32'h02, 1'b0, 5'd7);
        repeat (3) idle_step(1'b0);

        // Fill under stall until ready drops, then release.
        step(1'b1, 5'd1, 32'h101, 1'b1, 5'd2, 32'h102, 1'b1, 5'd1);
        step(1'b1, 5'd3, 32'h103, 1'b1, 5'd4, 32'h104, 1'b1, 5'd4);
        step(1'b1, 5'd8, 32'h1FF, 1'b1, 5'd9, 32'h1FE, 1'b1, 5'd8);
        repeat (4) idle_step(1'b0);

        // Bypass: two writes to the same register held under stall.
        step(1'b1, 5'd9, 32'h10, 1'b0, '0, '0, 1'b1, 5'd9);
        step(1'b1, 5'd9, 32'h20, 1'b0, '0, '0, 1'b1, 5'd9);
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd9);
        repeat (3) idle_step(1'b0);

        // Reset discards buffered writes.
        step(1'b1, 5'd10, 32'h55, 1'b1, 5'd11, 32'h66, 1'b1, 5'd10);
        step(1'b1, 5'd12, 32'h77, 1'b0, '0, '0, 1'b1, 5'd12);
        do_reset();
        repeat (4) idle_step(1'b0);

        // Randomized traffic with a small address space to provoke collisions.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom),
                 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom),
                 ($urandom_range(0, 3) == 0), AW'($urandom_range(0, 7)));
        end
        repeat (8) idle_step(1'b0);
        chk("drain_pending", exq.size(), 32'd0);
        chk("drain_idle", {31'd0, idle_o}, 32'd1);

        run = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
